// File: rtl/dot_square_detect.sv
// Bounding-box detector: tracks the extent and colour of all non-zero pixels
// seen in a frame and reports them one cycle after the frame-end pulse.
module dot_square_detect #(
    parameter int pHdisplayWidth = 11,
    parameter int pVdisplayWidth = 11,
    parameter int pColorDepth    = 16
) (
    input  logic                      iClk,
    input  logic                      iRst,
    input  logic [pColorDepth-1:0]    iPixel,
    input  logic                      iPixelVld,
    input  logic [pHdisplayWidth-1:0] iHpos,
    input  logic [pVdisplayWidth-1:0] iVpos,
    input  logic                      iFrameEnd,
    output logic [pHdisplayWidth-1:0] oDxs,
    output logic [pHdisplayWidth:0]   oDxe,
    output logic [pVdisplayWidth-1:0] oDys,
    output logic [pVdisplayWidth:0]   oDye,
    output logic [pColorDepth-1:0]    oColor,
    output logic                      oDetected,
    output logic                      oMultiColor,
    output logic [7:0]                oFrameCnt,
    output logic                      oVld
);

    typedef enum logic {EMPTY, FOUND} state_t;

    state_t                    state;
    logic [pHdisplayWidth-1:0] minX, maxX;
    logic [pVdisplayWidth-1:0] minY, maxY;
    logic [pColorDepth-1:0]    color;
    logic                      multi;

    logic                      hit;
    logic                      nFound;
    logic [pHdisplayWidth-1:0] nMinX, nMaxX;
    logic [pVdisplayWidth-1:0] nMinY, nMaxY;
    logic [pColorDepth-1:0]    nColor;
    logic                      nMulti;

    assign hit = iPixelVld && (iPixel != '0);

    // Accumulator values including this cycle's hit; the frame-end report
    // uses these so a hit coinciding with iFrameEnd is not lost.
    always_comb begin
        nFound = (state == FOUND) || hit;
        nMinX  = minX;
        nMaxX  = maxX;
        nMinY  = minY;
        nMaxY  = maxY;
        nColor = color;
        nMulti = multi;
        if (hit) begin
            if (state == EMPTY) begin
                nMinX  = iHpos;
                nMaxX  = iHpos;
                nMinY  = iVpos;
                nMaxY  = iVpos;
                nColor = iPixel;
                nMulti = 1'b0;
            end else begin
                if (iHpos < minX) nMinX = iHpos;
                if (iHpos > maxX) nMaxX = iHpos;
                if (iVpos < minY) nMinY = iVpos;
                if (iVpos > maxY) nMaxY = iVpos;
                if (iPixel != color) nMulti = 1'b1;
            end
        end
    end

    // Frame FSM, accumulators and registered report; frame end closes the
    // frame and re-arms EMPTY so the very next pixel starts a new frame.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state       <= EMPTY;
            minX        <= '0;
            maxX        <= '0;
            minY        <= '0;
            maxY        <= '0;
            color       <= '0;
            multi       <= 1'b0;
            oDxs        <= '0;
            oDxe        <= '0;
            oDys        <= '0;
            oDye        <= '0;
            oColor      <= '0;
            oDetected   <= 1'b0;
            oMultiColor <= 1'b0;
            oFrameCnt   <= 8'd0;
            oVld        <= 1'b0;
        end else begin
            oVld <= iFrameEnd;
            if (iFrameEnd) begin
                state     <= EMPTY;
                multi     <= 1'b0;
                oFrameCnt <= oFrameCnt + 8'd1;
                if (nFound) begin
                    oDxs        <= nMinX;
                    oDxe        <= {1'b0, nMaxX} + {{pHdisplayWidth{1'b0}}, 1'b1};
                    oDys        <= nMinY;
                    oDye        <= {1'b0, nMaxY} + {{pVdisplayWidth{1'b0}}, 1'b1};
                    oColor      <= nColor;
                    oDetected   <= 1'b1;
                    oMultiColor <= nMulti;
                end else begin
                    oDxs        <= '0;
                    oDxe        <= '0;
                    oDys        <= '0;
                    oDye        <= '0;
                    oColor      <= '0;
                    oDetected   <= 1'b0;
                    oMultiColor <= 1'b0;
                end
            end else begin
                state <= nFound ? FOUND : EMPTY;
                minX  <= nMinX;
                maxX  <= nMaxX;
                minY  <= nMinY;
                maxY  <= nMaxY;
                color <= nColor;
                multi <= nMulti;
            end
        end
    end

endmodule

// File: tb/tb_dot_square_detect.sv
// Scoreboard bench for dot_square_detect: expected reports are queued at
// frame end and checked by an independent monitor whenever oVld fires.
module tb_dot_square_detect;

    logic        iClk = 1'b0;
    logic        iRst;
    logic [15:0] iPixel;
    logic        iPixelVld;
    logic [10:0] iHpos;
    logic [10:0] iVpos;
    logic        iFrameEnd;
    logic [10:0] oDxs;
    logic [11:0] oDxe;
    logic [10:0] oDys;
    logic [11:0] oDye;
    logic [15:0] oColor;
    logic        oDetected;
    logic        oMultiColor;
    logic [7:0]  oFrameCnt;
    logic        oVld;

    typedef struct packed {
        logic [10:0] dxs;
        logic [11:0] dxe;
        logic [10:0] dys;
        logic [11:0] dye;
        logic [15:0] color;
        logic        det;
        logic        multi;
        logic [7:0]  cnt;
    } rep_t;

    rep_t q[$];
    rep_t held;
    rep_t act;
    logic [7:0] expCnt;
    bit   started = 0;
    int   checks = 0;
    int   errors = 0;

    dot_square_detect dut (
        .iClk(iClk), .iRst(iRst), .iPixel(iPixel), .iPixelVld(iPixelVld),
        .iHpos(iHpos), .iVpos(iVpos), .iFrameEnd(iFrameEnd),
        .oDxs(oDxs), .oDxe(oDxe), .oDys(oDys), .oDye(oDye), .oColor(oColor),
        .oDetected(oDetected), .oMultiColor(oMultiColor),
        .oFrameCnt(oFrameCnt), .oVld(oVld)
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string name, input logic [79:0] a, input logic [79:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, a, e);
        end
    endtask

    assign act = '{dxs: oDxs, dxe: oDxe, dys: oDys, dye: oDye, color: oColor,
                   det: oDetected, multi: oMultiColor, cnt: oFrameCnt};

    // Monitor: pop on each report, otherwise outputs must hold last report.
    always @(negedge iClk) begin
        if (iRst) begin
            held = '0;
        end else if (started) begin
            if (oVld) begin
                if (q.size() == 0) begin
                    chk("unexpected_vld", 1, 0);
                end else begin
                    rep_t e;
                    e = q.pop_front();
                    chk("dxs",   act.dxs,   e.dxs);
                    chk("dxe",   act.dxe,   e.dxe);
                    chk("dys",   act.dys,   e.dys);
                    chk("dye",   act.dye,   e.dye);
                    chk("color", act.color, e.color);
                    chk("det",   act.det,   e.det);
                    chk("multi", act.multi, e.multi);
                    chk("cnt",   act.cnt,   e.cnt);
                    held = e;
                end
            end else begin
                chk("hold", act, held);
            end
        end
    end

    // One cycle of input; strobes return to idle afterwards.
    task automatic drive(input int h, input int v, input logic [15:0] p,
                         input logic vld, input logic fe);
        iHpos     = h[10:0];
        iVpos     = v[10:0];
        iPixel    = p;
        iPixelVld = vld;
        iFrameEnd = fe;
        @(posedge iClk); #1;
        iPixelVld = 1'b0;
        iFrameEnd = 1'b0;
        iPixel    = '0;
    endtask

    task automatic expect_rep(input int xs, input int xe, input int ys, input int ye,
                              input logic [15:0] c, input logic d, input logic m);
        rep_t r;
        expCnt = expCnt + 8'd1;
        r = '{dxs: xs[10:0], dxe: xe[11:0], dys: ys[10:0], dye: ye[11:0],
              color: c, det: d, multi: m, cnt: expCnt};
        q.push_back(r);
    endtask

    task automatic do_reset();
        iRst = 1'b1;
        @(posedge iClk); #1;
        iRst = 1'b0;
        expCnt = 8'd0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 20) begin
            @(posedge iClk); #1;
            n++;
        end
        if (q.size() != 0) begin
            chk("report_timeout", q.size(), 0);
            q.delete();
        end
    endtask

    initial begin
        iRst = 1'b1; iPixel = '0; iPixelVld = 0; iHpos = '0; iVpos = '0; iFrameEnd = 0;
        expCnt = 8'd0;
        repeat (3) @(posedge iClk);
        #1;
        iRst = 1'b0;
        started = 1;
        chk("rst_vld", oVld, 0);
        chk("rst_cnt", oFrameCnt, 0);
        chk("rst_det", oDetected, 0);
        chk("rst_dxe", oDxe, 0);

        // Every row of a 640x480 raster (columns 0-31 plus the right edge),
        // red 10x3 block, frame end on the last pixel.
        for (int y = 0; y < 480; y++) begin
            for (int x = 0; x < 33; x++) begin
                int xx;
                logic [15:0] p;
                xx = (x == 32) ? 639 : x;
                p = (xx >= 10 && xx < 20 && y >= 5 && y < 8) ? 16'hF800 : 16'h0000;
                if (xx == 639 && y == 479) expect_rep(10, 20, 5, 8, 16'hF800, 1, 0);
                drive(xx, y, p, 1'b1, (xx == 639 && y == 479));
            end
        end
        drain();

        // All-zero frame.
        for (int i = 0; i < 5; i++) drive(i, i, 16'h0000, 1'b1, 1'b0);
        expect_rep(0, 0, 0, 0, 16'h0000, 0, 0);
        drive(0, 0, 16'h0000, 1'b0, 1'b1);
        drain();

        // Single hit at the coordinate ceiling, coinciding with frame end.
        expect_rep(2047, 2048, 2047, 2048, 16'h07E0, 1, 0);
        drive(2047, 2047, 16'h07E0, 1'b1, 1'b1);
        drain();

        // Out-of-raster order, two colours.
        drive(3, 3, 16'h001F, 1'b1, 1'b0);
        drive(9, 1, 16'h0020, 1'b1, 1'b0);
        expect_rep(3, 10, 1, 4, 16'h001F, 1, 1);
        drive(0, 0, 16'h0000, 1'b0, 1'b1);
        drain();

        // Back-to-back frame ends: second report is empty.
        expect_rep(4, 5, 6, 7, 16'h1234, 1, 0);
        drive(4, 6, 16'h1234, 1'b1, 1'b1);
        expect_rep(0, 0, 0, 0, 16'h0000, 0, 0);
        drive(0, 0, 16'h0000, 1'b0, 1'b1);
        drain();

        // Non-zero pixel without valid is ignored.
        drive(100, 100, 16'hFFFF, 1'b0, 1'b0);
        drive(7, 8, 16'h0ABC, 1'b1, 1'b0);
        expect_rep(7, 8, 8, 9, 16'h0ABC, 1, 0);
        drive(0, 0, 16'h0000, 1'b0, 1'b1);
        drain();

        // Mid-frame reset with a hit and frame end in the reset cycle.
        drive(5, 5, 16'h00FF, 1'b1, 1'b0);
        iRst = 1'b1;
        drive(6, 6, 16'h00FF, 1'b1, 1'b1);
        iRst = 1'b0;
        expCnt = 8'd0;
        @(posedge iClk); #1;
        chk("midrst_cnt", oFrameCnt, 0);
        chk("midrst_vld", oVld, 0);
        expect_rep(1, 2, 1, 2, 16'h0001, 1, 0);
        drive(1, 1, 16'h0001, 1'b1, 1'b1);
        drain();

        // Frame counter wrap after 256 empty frames.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            expect_rep(0, 0, 0, 0, 16'h0000, 0, 0);
            drive(0, 0, 16'h0000, 1'b0, 1'b1);
        end
        drain();
        chk("wrap_cnt", oFrameCnt, 0);

        repeat (3) @(posedge iClk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
